// File: rtl/frame_sequencer.sv
// Frame-timing controller for the orange-pixel datapath: camera strobes -> col/row/region + accumulate/decide/clear.
// Latency: accum_en/col/row/region one cycle after pix_valid; decide 2 cycles after the last href fall, clear one cycle later.
// No backpressure: the camera is free-running; short frames and bad line lengths are flagged on frame_err.
//
// Ports: clk/reset (async, active-high); enable, vsync, href, pix_valid, frame_skip[1:0] in;
//        col[8:0], row[7:0], region[1:0], accum_en, decide, clear, frame_err, busy, frame_count[15:0] out.
module frame_sequencer #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int LEFT_END    = 70,
  parameter int RIGHT_START = 290
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        vsync,
  input  logic        href,
  input  logic        pix_valid,
  input  logic [1:0]  frame_skip,
  output logic [8:0]  col,
  output logic [7:0]  row,
  output logic [1:0]  region,
  output logic        accum_en,
  output logic        decide,
  output logic        clear,
  output logic        frame_err,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam logic [8:0] H_W     = 9'(H_ACTIVE);
  localparam logic [8:0] LEFT_W  = 9'(LEFT_END);
  localparam logic [8:0] RIGHT_W = 9'(RIGHT_START);
  localparam logic [7:0] V_W     = 8'(V_ACTIVE);
  localparam logic [7:0] V_LAST  = 8'(V_ACTIVE - 1);

  typedef enum logic [2:0] {IDLE, SKIP, ARMED, LINE, GAP, DECIDE, CLEAR} state_t;

  state_t     state;
  logic       vsync_q, href_q;
  logic       vs_pend;   // vsync rise seen in DECIDE/CLEAR, served once back in IDLE
  logic       restart;   // CLEAR was entered by a short frame: go straight to ARMED
  logic [1:0] skip_cnt;
  logic [8:0] col_cnt;
  logic [7:0] row_cnt;

  logic       vs_rise, href_rise, href_fall;
  logic       pix_take;
  logic [8:0] col_nxt;

  assign vs_rise   = vsync & ~vsync_q;
  assign href_rise = href & ~href_q;
  assign href_fall = ~href & href_q;

  // A pixel counts while in LINE (including the cycle href falls, so it is taken
  // before the line closes) or on the very cycle href rises. A vsync rise wins:
  // that cycle belongs to the aborted frame.
  assign pix_take = pix_valid & ~vs_rise &
                    ((state == LINE) | (((state == ARMED) | (state == GAP)) & href_rise));
  assign col_nxt  = (pix_take && col_cnt < H_W) ? col_cnt + 9'd1 : col_cnt;

  function automatic logic [1:0] region_of(input logic [8:0] c);
    if (c < LEFT_W)       return 2'd0;
    else if (c < RIGHT_W) return 2'd1;
    else if (c < H_W)     return 2'd2;
    else                  return 2'd3;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      vs_pend     <= 1'b0;
      restart     <= 1'b0;
      skip_cnt    <= 2'd0;
      col_cnt     <= 9'd0;
      row_cnt     <= 8'd0;
      col         <= 9'd0;
      row         <= 8'd0;
      region      <= 2'd3;
      accum_en    <= 1'b0;
      decide      <= 1'b0;
      clear       <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      vsync_q  <= vsync;
      href_q   <= href;
      accum_en <= 1'b0;
      decide   <= 1'b0;
      clear    <= 1'b0;

      if (pix_take) begin
        if (col_cnt < H_W) begin
          accum_en <= 1'b1;
          col      <= col_cnt;
          row      <= row_cnt;
          region   <= region_of(col_cnt);
        end else begin
          frame_err <= 1'b1;   // overlong line: pixel dropped
        end
        col_cnt <= col_nxt;
      end

      case (state)
        IDLE: begin
          vs_pend <= 1'b0;
          if ((vs_rise | vs_pend) & enable) begin
            busy <= 1'b1;
            if (skip_cnt == 2'd0) begin
              state     <= ARMED;
              frame_err <= 1'b0;
              skip_cnt  <= frame_skip;
              row_cnt   <= 8'd0;
              col_cnt   <= 9'd0;
            end else begin
              state    <= SKIP;
              skip_cnt <= skip_cnt - 2'd1;
            end
          end
        end
        SKIP: begin
          if (vs_rise) begin
            if (!enable) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (skip_cnt == 2'd0) begin
              state     <= ARMED;
              frame_err <= 1'b0;
              skip_cnt  <= frame_skip;
              row_cnt   <= 8'd0;
              col_cnt   <= 9'd0;
            end else begin
              skip_cnt <= skip_cnt - 2'd1;
            end
          end
        end
        ARMED: begin
          if (href_rise && !vs_rise) state <= LINE;
        end
        LINE: begin
          if (vs_rise) begin
            frame_err <= 1'b1;
            restart   <= 1'b1;
            state     <= CLEAR;
          end else if (href_fall) begin
            if (col_nxt != H_W) frame_err <= 1'b1;
            col_cnt <= 9'd0;
            row_cnt <= (row_cnt < V_W) ? row_cnt + 8'd1 : row_cnt;
            state   <= (row_cnt == V_LAST) ? DECIDE : GAP;
          end
        end
        GAP: begin
          if (vs_rise) begin
            frame_err <= 1'b1;
            restart   <= 1'b1;
            state     <= CLEAR;
          end else if (href_rise) begin
            state <= LINE;
          end
        end
        DECIDE: begin
          decide      <= 1'b1;
          frame_count <= frame_count + 16'd1;
          state       <= CLEAR;
          if (vs_rise) vs_pend <= 1'b1;
        end
        CLEAR: begin
          clear <= 1'b1;
          if (restart) begin
            // The vsync that cut the frame short is the start of this one.
            restart   <= 1'b0;
            state     <= ARMED;
            frame_err <= 1'b0;
            skip_cnt  <= frame_skip;
            row_cnt   <= 8'd0;
            col_cnt   <= 9'd0;
          end else begin
            if (vs_rise) vs_pend <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer on a reduced geometry (20x6 pixels, regions 5/12/3 per line).
// Per-pixel scoreboard built from line/pixel indices; per-frame decide/clear/err checks.
// Scenario table plus hand-written reset/enable/short-frame sequences and a randomized run.
module tb_frame_sequencer;
  localparam int H = 20, V = 6, LE = 5, RS = 17;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        vsync = 1'b0, href = 1'b0, pix_valid = 1'b0;
  logic [1:0]  frame_skip = 2'd0;
  logic [8:0]  col;
  logic [7:0]  row;
  logic [1:0]  region;
  logic        accum_en, decide, clear, frame_err, busy;
  logic [15:0] frame_count;

  frame_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V), .LEFT_END(LE), .RIGHT_START(RS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .vsync(vsync), .href(href),
    .pix_valid(pix_valid), .frame_skip(frame_skip), .col(col), .row(row),
    .region(region), .accum_en(accum_en), .decide(decide), .clear(clear),
    .frame_err(frame_err), .busy(busy), .frame_count(frame_count));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [18:0] expq[$];
  logic [18:0] mon_e;
  int  lens_q[$];
  int  n_acc = 0, n_dec = 0, n_clr = 0;
  int  rc[4] = '{0, 0, 0, 0};
  bit  dec_err = 0;
  int  dec_cyc = 0, clr_cyc = 0, fall_cyc = 0;
  int  skip_rem = 0, fc_exp = 0, en_drop_line = -1;

  typedef struct {
    int skip; int nfr; int mode;
    int dec; int acc; int l; int c; int r; bit err;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic int reg_of(input int c);
    return (c < LE) ? 0 : (c < RS) ? 1 : (c < H) ? 2 : 3;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (accum_en) begin
        n_acc++;
        rc[region]++;
        if (expq.size() == 0) check("unexpected_accum", {col, row, region}, 19'h7ffff);
        else begin
          mon_e = expq.pop_front();
          check("pixel", {col, row, region}, mon_e);
        end
      end
      if (decide) begin n_dec++; dec_err = frame_err; dec_cyc = cyc; end
      if (clear)  begin n_clr++; clr_cyc = cyc; end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1; tick(2); vsync = 1'b0; tick(2);
  endtask

  task automatic fill_lens(input int mode);
    lens_q.delete();
    for (int l = 0; l < V; l++) lens_q.push_back(H);
    if (mode == 1) begin lens_q[2] = H - 2; lens_q[3] = H + 2; end
  endtask

  task automatic push_pix(input int p, input int r);
    expq.push_back({9'(p), 8'(r), 2'(reg_of(p))});
  endtask

  task automatic drive_line(input int n, input int r, input bit proc, input bit rnd);
    int p;
    bit fall_same;
    p = 0;
    fall_same = rnd && ($urandom_range(0, 2) == 0);
    href = 1'b1;
    if (rnd && $urandom_range(0, 2) == 0) begin
      pix_valid = 1'b1;
      if (proc) push_pix(p, r);
      p++;
    end else pix_valid = 1'b0;
    tick(1);
    while (p < n) begin
      if (rnd && $urandom_range(0, 3) == 0) pix_valid = 1'b0;
      else begin
        pix_valid = 1'b1;
        if (proc && p < H) push_pix(p, r);
        if (fall_same && p == n - 1) begin href = 1'b0; fall_cyc = cyc; end
        p++;
      end
      tick(1);
    end
    pix_valid = 1'b0;
    if (href) begin href = 1'b0; fall_cyc = cyc; tick(1); end
    tick(1);
    if (rnd) begin pix_valid = 1'b1; tick(1); pix_valid = 1'b0; end
    tick(1);
  endtask

  task automatic wait_clear(input int c0);
    for (int i = 0; i < 40 && n_clr == c0; i++) tick(1);
  endtask

  task automatic run_frame(input bit start_vs, input int abort_after, input bit rnd);
    bit proc, err_exp;
    int d0, c0, a0, nl;
    d0 = n_dec; c0 = n_clr; a0 = n_acc; err_exp = 0;
    if (!start_vs)          begin proc = 1; skip_rem = frame_skip; end
    else if (skip_rem == 0) begin proc = 1; skip_rem = frame_skip; end
    else                    begin proc = 0; skip_rem--; end
    if (start_vs) pulse_vsync();
    nl = (abort_after >= 0) ? abort_after : lens_q.size();
    for (int l = 0; l < nl; l++) begin
      if (l == en_drop_line) enable = 1'b0;
      drive_line(lens_q[l], l, proc, rnd);
      if (lens_q[l] != H) err_exp = 1;
      if (l == 0) check("busy_mid_frame", busy, 1);
    end
    if (abort_after >= 0) begin
      pulse_vsync();
      wait_clear(c0);
      check("short_no_decide", n_dec - d0, 0);
      check("short_clear", n_clr - c0, 1);
    end else if (proc) begin
      wait_clear(c0);
      tick(2);
      fc_exp++;
      check("decide_cnt", n_dec - d0, 1);
      check("clear_cnt", n_clr - c0, 1);
      check("frame_err_at_decide", dec_err, err_exp);
      check("decide_latency", dec_cyc - fall_cyc, 2);
      check("clear_after_decide", clr_cyc - dec_cyc, 1);
      check("busy_idle", busy, 0);
    end else begin
      tick(3);
      check("skip_no_decide", n_dec - d0, 0);
      check("skip_no_accum", n_acc - a0, 0);
    end
    check("frame_count", frame_count, fc_exp);
    check("scoreboard_drained", expq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, col, 0);
    check({tag, "_row"}, row, 0);
    check({tag, "_region"}, region, 3);
    check({tag, "_accum"}, accum_en, 0);
    check({tag, "_decide"}, decide, 0);
    check({tag, "_clear"}, clear, 0);
    check({tag, "_err"}, frame_err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fcount"}, frame_count, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; href = 1'b0; vsync = 1'b0; pix_valid = 1'b0; enable = 1'b1;
    tick(2);
    expq.delete(); skip_rem = 0; fc_exp = 0;
    check_reset_outputs("rst");
    reset = 1'b0;
    tick(2);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, a0, l0, c0, r0;
    bit cont;
    int ab;

    tbl[0] = '{0, 2, 0, 2, 240, 60, 144, 36, 1'b0};
    tbl[1] = '{2, 6, 0, 2, 240, 60, 144, 36, 1'b0};
    tbl[2] = '{0, 1, 1, 1, 118, 30,  72, 16, 1'b1};
    tbl[3] = '{3, 5, 0, 2, 240, 60, 144, 36, 1'b0};
    tbl[4] = '{1, 3, 1, 2, 236, 60, 144, 32, 1'b1};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      frame_skip = 2'(tbl[i].skip);
      d0 = n_dec; a0 = n_acc; l0 = rc[0]; c0 = rc[1]; r0 = rc[2];
      for (int f = 0; f < tbl[i].nfr; f++) begin
        fill_lens(tbl[i].mode);
        run_frame(1, -1, 0);
      end
      check("tbl_decides", n_dec - d0, tbl[i].dec);
      check("tbl_accum", n_acc - a0, tbl[i].acc);
      check("tbl_left", rc[0] - l0, tbl[i].l);
      check("tbl_center", rc[1] - c0, tbl[i].c);
      check("tbl_right", rc[2] - r0, tbl[i].r);
      check("tbl_err", dec_err, tbl[i].err);
      check("tbl_fcount", frame_count, tbl[i].dec);
    end

    // Short frame: vsync after line 2 -> clear without decide, then a clean frame.
    do_reset();
    frame_skip = 2'd0;
    fill_lens(0);
    run_frame(1, 2, 0);
    run_frame(0, -1, 0);

    // Asynchronous reset in the middle of line 3, pixel 7.
    run_frame(1, -1, 0);
    pulse_vsync();
    for (int l = 0; l < 3; l++) drive_line(H, l, 1, 0);
    href = 1'b1; tick(1);
    for (int p = 0; p < 7; p++) begin pix_valid = 1'b1; push_pix(p, 3); tick(1); end
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_rst");
    expq.delete();
    pix_valid = 1'b0; href = 1'b0;
    tick(2);
    reset = 1'b0; skip_rem = 0; fc_exp = 0;
    tick(1);
    a0 = n_acc;
    drive_line(H, 0, 0, 0);
    drive_line(H, 1, 0, 0);
    check("post_rst_no_accum", n_acc - a0, 0);
    check("post_rst_busy", busy, 0);
    fill_lens(0);
    run_frame(1, -1, 0);

    // Enable dropped at row 3: frame still completes; vsync while disabled is ignored.
    en_drop_line = 3;
    run_frame(1, -1, 0);
    en_drop_line = -1;
    a0 = n_acc; d0 = n_dec;
    pulse_vsync();
    check("disabled_busy_a", busy, 0);
    drive_line(H, 0, 0, 0);
    drive_line(H, 1, 0, 0);
    check("disabled_busy_b", busy, 0);
    check("disabled_no_accum", n_acc - a0, 0);
    check("disabled_no_decide", n_dec - d0, 0);
    enable = 1'b1;
    run_frame(1, -1, 0);

    // Randomized frames: skip values, line-length faults, short frames, pixel jitter.
    do_reset();
    cont = 0;
    for (int f = 0; f < 30; f++) begin
      if (!cont) frame_skip = 2'($urandom_range(0, 3));
      fill_lens(0);
      if ($urandom_range(0, 3) == 0) lens_q[$urandom_range(0, V - 1)] = H + $urandom_range(0, 4) - 2;
      ab = -1;
      if ((cont || skip_rem == 0) && $urandom_range(0, 4) == 0) ab = $urandom_range(1, V - 1);
      run_frame(!cont, ab, 1);
      cont = (ab >= 0);
    end
    if (cont) begin
      fill_lens(0);
      run_frame(0, -1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
